// File: rtl/ssm_stream_sequencer_pkg.sv
// Shared constants for the SSM stream sequencer: word width, operand field
// offsets within a load frame, frame length and the sequencer state encoding.
package ssm_stream_sequencer_pkg;

    localparam int SSM_DW = 16;
    localparam int SSM_H  = 4;
    localparam int SSM_P  = 4;
    localparam int SSM_N  = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4
    } ssm_state_e;

    // Field order in a frame: dt[H], dA[H], Bmat[N], C[N], D[H], x[H*P], h_prev[H*P*N]
    function automatic int off_da(input int h);
        return h;
    endfunction

    function automatic int off_b(input int h);
        return 2 * h;
    endfunction

    function automatic int off_c(input int h, input int n);
        return 2 * h + n;
    endfunction

    function automatic int off_d(input int h, input int n);
        return 2 * h + 2 * n;
    endfunction

    function automatic int off_x(input int h, input int n);
        return 3 * h + 2 * n;
    endfunction

    function automatic int off_hp(input int h, input int p, input int n);
        return 3 * h + 2 * n + h * p;
    endfunction

    function automatic int frame_len(input int h, input int p, input int n);
        return 3 * h + 2 * n + h * p + h * p * n;
    endfunction

    localparam int OFF_DT = 0;
    localparam int OFF_DA = off_da(SSM_H);
    localparam int OFF_B  = off_b(SSM_H);
    localparam int OFF_C  = off_c(SSM_H, SSM_N);
    localparam int OFF_D  = off_d(SSM_H, SSM_N);
    localparam int OFF_X  = off_x(SSM_H, SSM_N);
    localparam int OFF_H  = off_hp(SSM_H, SSM_P, SSM_N);
    localparam int FRAME_L = frame_len(SSM_H, SSM_P, SSM_N);

endpackage

// File: rtl/ssm_stream_sequencer_word_serializer.sv
// Drain side of the sequencer: captures the flat y result and replays it
// word by word on a valid/ready stream, flagging the final word.
module ssm_word_serializer #(
    parameter int NW = 16,
    parameter int DW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [NW*DW-1:0] y_flat,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [DW-1:0]    out_data,
    output logic             out_last,
    output logic             done
);
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;

    logic [NW*DW-1:0] ybuf;
    logic [IW-1:0]    idx;
    logic             active;
    logic             fire;

    // Word j always sits in the low slot; ybuf only shifts on a handshake, so
    // data and last stay put while the consumer stalls.
    assign out_valid = active;
    assign out_data  = ybuf[DW-1:0];
    assign out_last  = active && (idx == IW'(NW - 1));
    assign fire      = active && out_ready;
    assign done      = fire && out_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ybuf   <= '0;
            idx    <= '0;
            active <= 1'b0;
        end else if (load) begin
            ybuf   <= y_flat;
            idx    <= '0;
            active <= 1'b1;
        end else if (fire) begin
            ybuf <= ybuf >> DW;
            idx  <= idx + 1'b1;
            if (out_last) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ssm_stream_sequencer.sv
// Initiator-side sequencer for the SSM FP16 compute block: loads one operand
// frame from a word stream, kicks the block, and streams the y result back out.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready for the first word of a frame (lands in dt[0])
// LOAD     | accepting the remaining frame words into the operand registers
// START    | one-cycle ssm_start pulse, input held off
// WAIT     | watchdog running until ssm_done or expiry
// DRAIN    | streaming captured y words out
module ssm_stream_sequencer
    import ssm_stream_sequencer_pkg::*;
#(
    parameter int H        = SSM_H,
    parameter int P        = SSM_P,
    parameter int N        = SSM_N,
    parameter int DW       = SSM_DW,
    parameter int WAIT_MAX = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_data,
    output logic                out_last,
    output logic                ssm_start,
    input  logic                ssm_done,
    output logic [H*DW-1:0]     dt_flat,
    output logic [H*DW-1:0]     dA_flat,
    output logic [H*DW-1:0]     D_flat,
    output logic [N*DW-1:0]     Bmat_flat,
    output logic [N*DW-1:0]     C_flat,
    output logic [H*P*DW-1:0]   x_flat,
    output logic [H*P*N*DW-1:0] h_prev_flat,
    input  logic [H*P*DW-1:0]   ssm_y_flat,
    output logic                busy,
    output logic                err_timeout
);
    localparam int L    = frame_len(H, P, N);
    localparam int O_DT = 0;
    localparam int O_DA = off_da(H);
    localparam int O_B  = off_b(H);
    localparam int O_C  = off_c(H, N);
    localparam int O_D  = off_d(H, N);
    localparam int O_X  = off_x(H, N);
    localparam int O_HP = off_hp(H, P, N);
    localparam int WCW  = $clog2(L + 1);
    localparam int TW   = $clog2(WAIT_MAX + 1);

    ssm_state_e     state, state_nxt;
    logic           armed;
    logic [WCW-1:0] wcnt;
    logic [WCW-1:0] word_idx;
    logic [TW-1:0]  wdog;
    logic           wdog_tc;
    logic           in_fire;
    logic           last_word;
    logic           y_load;
    logic           drain_done;

    assign in_fire   = in_valid && in_ready;
    assign word_idx  = (state == ST_IDLE) ? '0 : wcnt;
    assign last_word = (wcnt == WCW'(L - 1));
    assign wdog_tc   = (wdog == '0);
    assign y_load    = (state == ST_WAIT) && ssm_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (in_fire) state_nxt = ST_LOAD;
            ST_LOAD:  if (in_fire && last_word) state_nxt = ST_START;
            ST_START: state_nxt = ST_WAIT;
            ST_WAIT: begin
                // done wins over a coincident watchdog expiry
                if (ssm_done) begin
                    state_nxt = ST_DRAIN;
                end else if (wdog_tc) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: if (drain_done) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // armed keeps in_ready low while reset is held and until the first clock after it
    always_comb begin
        in_ready  = armed && ((state == ST_IDLE) || (state == ST_LOAD));
        ssm_start = (state == ST_START);
        busy      = (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed       <= 1'b0;
            wcnt        <= '0;
            wdog        <= '0;
            err_timeout <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (in_fire) begin
                wcnt <= (state == ST_IDLE) ? WCW'(1) : wcnt + 1'b1;
            end
            // watchdog is a down-counter; expiry is the WAIT cycle it reads zero
            if (state == ST_START) begin
                wdog <= TW'(WAIT_MAX - 1);
            end else if ((state == ST_WAIT) && !wdog_tc) begin
                wdog <= wdog - 1'b1;
            end
            if ((state == ST_IDLE) && in_fire) begin
                err_timeout <= 1'b0;
            end else if ((state == ST_WAIT) && !ssm_done && wdog_tc) begin
                err_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dt_flat     <= '0;
            dA_flat     <= '0;
            D_flat      <= '0;
            Bmat_flat   <= '0;
            C_flat      <= '0;
            x_flat      <= '0;
            h_prev_flat <= '0;
        end else if (in_fire) begin
            for (int k = 0; k < H; k++) begin
                if (word_idx == WCW'(O_DT + k)) dt_flat[k*DW +: DW] <= in_data;
                if (word_idx == WCW'(O_DA + k)) dA_flat[k*DW +: DW] <= in_data;
                if (word_idx == WCW'(O_D + k))  D_flat[k*DW +: DW]  <= in_data;
            end
            for (int k = 0; k < N; k++) begin
                if (word_idx == WCW'(O_B + k)) Bmat_flat[k*DW +: DW] <= in_data;
                if (word_idx == WCW'(O_C + k)) C_flat[k*DW +: DW]    <= in_data;
            end
            for (int k = 0; k < H * P; k++) begin
                if (word_idx == WCW'(O_X + k)) x_flat[k*DW +: DW] <= in_data;
            end
            for (int k = 0; k < H * P * N; k++) begin
                if (word_idx == WCW'(O_HP + k)) h_prev_flat[k*DW +: DW] <= in_data;
            end
        end
    end

    ssm_word_serializer #(
        .NW (H * P),
        .DW (DW)
    ) u_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (y_load),
        .y_flat    (ssm_y_flat),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (drain_done)
    );

endmodule

// File: tb/tb_ssm_stream_sequencer.sv
// Self-checking bench for ssm_stream_sequencer: frame loads, compute handshake,
// watchdog expiry, reset abort and output stream scoreboard.
module tb_ssm_stream_sequencer;
    localparam int H    = 4;
    localparam int P    = 4;
    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int WMAX = 64;
    localparam int L    = 100;
    localparam int NY   = H * P;
    localparam int B_DT = 0;
    localparam int B_DA = 4;
    localparam int B_B  = 8;
    localparam int B_C  = 12;
    localparam int B_D  = 16;
    localparam int B_X  = 20;
    localparam int B_HP = 36;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [DW-1:0]       in_data = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [DW-1:0]       out_data;
    logic                out_last;
    logic                ssm_start;
    logic                ssm_done = 1'b0;
    logic [H*DW-1:0]     dt_flat, dA_flat, D_flat;
    logic [N*DW-1:0]     Bmat_flat, C_flat;
    logic [H*P*DW-1:0]   x_flat;
    logic [H*P*N*DW-1:0] h_prev_flat;
    logic [H*P*DW-1:0]   ssm_y_flat = '0;
    logic                busy;
    logic                err_timeout;

    always #5 clk = ~clk;

    ssm_stream_sequencer #(
        .H(H), .P(P), .N(N), .DW(DW), .WAIT_MAX(WMAX)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .ssm_start   (ssm_start),
        .ssm_done    (ssm_done),
        .dt_flat     (dt_flat),
        .dA_flat     (dA_flat),
        .D_flat      (D_flat),
        .Bmat_flat   (Bmat_flat),
        .C_flat      (C_flat),
        .x_flat      (x_flat),
        .h_prev_flat (h_prev_flat),
        .ssm_y_flat  (ssm_y_flat),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          start_cnt = 0;
    logic [DW:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [DW:0] prev_word = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard pop on each handshake, hold check on each stall
    always @(negedge clk) begin
        logic [DW:0] e;
        if (ssm_start) start_cnt++;
        if (out_valid && prev_stall) chk("stall_hold", {out_last, out_data}, prev_word);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_word", {out_last, out_data}, e);
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_word  = {out_last, out_data};
    end

    function automatic logic [DW-1:0] wv(input int i, input logic [DW-1:0] xv);
        return DW'(i) ^ xv;
    endfunction

    task automatic send_words(input int first, input int count, input logic [DW-1:0] xv, input int gap);
        int b;
        for (int k = first; k < first + count; k++) begin
            while (gap > 0 && $urandom_range(99) < gap) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = wv(k, xv);
            b = 0;
            @(negedge clk);
            while (!in_ready && b < 50) begin
                @(negedge clk);
                b++;
            end
            if (b >= 50) chk("in_ready_timeout", in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic check_ops(input logic [DW-1:0] xv);
        for (int k = 0; k < H; k++) begin
            chk("dt",  dt_flat[k*DW +: DW], wv(B_DT + k, xv));
            chk("dA",  dA_flat[k*DW +: DW], wv(B_DA + k, xv));
            chk("D",   D_flat[k*DW +: DW],  wv(B_D + k, xv));
        end
        for (int k = 0; k < N; k++) begin
            chk("Bmat", Bmat_flat[k*DW +: DW], wv(B_B + k, xv));
            chk("C",    C_flat[k*DW +: DW],    wv(B_C + k, xv));
        end
        for (int h = 0; h < H; h++)
            for (int p = 0; p < P; p++) begin
                chk("x", x_flat[(h*P+p)*DW +: DW], wv(B_X + h*P + p, xv));
                for (int n = 0; n < N; n++)
                    chk("h_prev", h_prev_flat[((h*P+p)*N+n)*DW +: DW],
                        wv(B_HP + (h*P+p)*N + n, xv));
            end
    endtask

    // Compute-block model: done `delay` WAIT cycles in, with y pushed to the scoreboard
    task automatic run_compute(input int delay, input bit rnd);
        logic [DW-1:0] y;
        repeat (delay) @(posedge clk);
        #1;
        for (int j = 0; j < NY; j++) begin
            y = rnd ? DW'($urandom) : DW'(16'h3C00 + j);
            ssm_y_flat[j*DW +: DW] = y;
            exp_q.push_back({(j == NY - 1), y});
        end
        ssm_done = 1'b1;
        @(posedge clk); #1;
        ssm_done = 1'b0;
        chk("first_out_valid", out_valid, 1);
    endtask

    task automatic drain(input bit rnd, input int exp_cycles);
        int b;
        b = 0;
        while (busy && b < 400) begin
            out_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
            @(posedge clk); #1;
            b++;
        end
        out_ready = 1'b1;
        if (b >= 400) chk("drain_timeout", busy, 0);
        if (!rnd) chk("drain_cycles", b, exp_cycles);
        chk("drain_busy", busy, 0);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    task automatic check_start(input int sc0);
        chk("start_pulse", ssm_start, 1);
        chk("start_in_ready", in_ready, 0);
        @(posedge clk); #1;
        chk("start_one_cycle", ssm_start, 0);
        chk("start_count", start_cnt - sc0, 1);
    endtask

    initial begin
        int sc;
        #2 rst_n = 1'b0;
        #4;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_start", ssm_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_dt", dt_flat, 0);
        chk("rst_hprev_nz", (h_prev_flat != '0), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", in_ready, 1);

        // 1: back-to-back frame, word value = index
        sc = start_cnt;
        send_words(0, L, 16'h0000, 0);
        check_start(sc);
        chk("dt0", dt_flat[15:0], 16'h0000);
        chk("bmat0", Bmat_flat[15:0], 16'h0008);
        chk("hprev_last", h_prev_flat[63*DW +: DW], 16'h0063);
        check_ops(16'h0000);
        run_compute(19, 1'b0);
        drain(1'b0, NY);

        // 2: random input gaps, random output backpressure
        sc = start_cnt;
        send_words(0, L, 16'h1200, 50);
        check_start(sc);
        check_ops(16'h1200);
        run_compute(6, 1'b1);
        drain(1'b1, NY);
        check_ops(16'h1200);

        // 3: no done -> watchdog expiry on WAIT cycle 64
        sc = start_cnt;
        send_words(0, L, 16'h0300, 0);
        chk("to_start", ssm_start, 1);
        repeat (WMAX) @(posedge clk);
        #1;
        chk("to_still_wait", busy, 1);
        chk("to_err_pre", err_timeout, 0);
        @(posedge clk); #1;
        chk("to_err", err_timeout, 1);
        chk("to_idle", busy, 0);
        chk("to_out_valid", out_valid, 0);
        chk("to_in_ready", in_ready, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("to_err_sticky", err_timeout, 1);
        chk("to_start_count", start_cnt - sc, 1);

        // 4: first word clears err; spurious done in LOAD; done coincident with expiry
        send_words(0, 30, 16'h4400, 0);
        chk("err_cleared", err_timeout, 0);
        ssm_done = 1'b1;
        @(posedge clk); #1;
        ssm_done = 1'b0;
        chk("spur_busy", busy, 1);
        chk("spur_in_ready", in_ready, 1);
        chk("spur_out_valid", out_valid, 0);
        sc = start_cnt;
        send_words(30, L - 30, 16'h4400, 0);
        chk("coinc_start", ssm_start, 1);
        check_ops(16'h4400);
        run_compute(WMAX, 1'b0);
        chk("coinc_err", err_timeout, 0);
        drain(1'b0, NY);
        chk("coinc_err_after", err_timeout, 0);
        chk("coinc_start_count", start_cnt - sc, 1);

        // 5: reset at word 50 of a load, then a complete new frame
        send_words(0, 50, 16'h7700, 0);
        sc = start_cnt;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_dt_cleared", dt_flat[15:0], 16'h0000);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_no_start", start_cnt - sc, 0);
        chk("abort_idle", busy, 0);
        send_words(0, L, 16'h0B00, 0);
        check_start(sc);
        check_ops(16'h0B00);
        run_compute(3, 1'b1);
        drain(1'b1, NY);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/ssm_stream_sequencer.md
Name: ssm_stream_sequencer

Overview:
- Initiator-side companion of the SSM FP16 compute block (start/done handshake, flattened operand buses).
- Deserialises one frame of FP16 operands from a valid/ready word stream into flat operand registers, pulses the compute block's start, and waits for its done.
- Captures the flattened y result and re-serialises it as a valid/ready output stream.
- Sits between the DMA/host stream interface and the SSM compute top.

Parameters:
- H, 4, number of heads.
- P, 4, head dimension.
- N, 4, state dimension.
- DW, 16, word width (FP16, bit pattern passed through untouched).
- WAIT_MAX, 4096, watchdog limit in cycles while waiting for ssm_done.
- (Batch fixed at 1; not a parameter.)

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid && in_ready.
- in_data  in  DW  input FP16 word.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream ready.
- out_data  out  DW  output y word.
- out_last  out  1  high with final y word of frame.
- ssm_start  out  1  one-cycle start pulse to compute block.
- ssm_done  in  1  compute block done pulse.
- dt_flat, dA_flat, D_flat  out  H*DW each  operand registers.
- Bmat_flat, C_flat  out  N*DW each  operand registers.
- x_flat  out  H*P*DW  operand register.
- h_prev_flat  out  H*P*N*DW  operand register.
- ssm_y_flat  in  H*P*DW  result from compute block.
- busy  out  1  high in any state other than IDLE.
- err_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst_n low, async): state IDLE; all counters and flat registers 0; in_ready, out_valid, out_last, ssm_start, busy, err_timeout all 0.
- Frame load order is fixed: dt[H], dA[H], Bmat[N], C[N], D[H], x[H*P], h_prev[H*P*N]. Total L = 3H + 2N + H*P + H*P*N words (100 at defaults).
- Element k of each field is written to bits [k*DW +: DW] of its flat bus. x index is h*P+p; h_prev index is (h*P+p)*N+n.
- States:
  - IDLE: in_ready=1. First accepted word writes dt[0], clears err_timeout, then LOAD.
  - LOAD: in_ready=1. Word counter advances by one per accepted handshake only; stalls when in_valid=0. Accepting word L-1 moves to START.
  - START: ssm_start=1 for exactly this cycle, in_ready=0, then WAIT.
  - WAIT: in_ready=0. Watchdog counts cycles. On ssm_done: capture ssm_y_flat into the output buffer in that same cycle, then DRAIN. If the watchdog reaches WAIT_MAX without done: set err_timeout, go IDLE, produce no output.
  - DRAIN: out_valid=1, out_data=ybuf[j], j = 0..H*P-1 ascending. j advances only on out_valid && out_ready. out_last=1 when j = H*P-1. Handshake on the last word goes to IDLE.
- Latency: START is entered the cycle after the L-th handshake. The first out_valid is the cycle after ssm_done.
- Output stall: out_data and out_last hold stable while out_valid && !out_ready.
- ssm_done outside WAIT is ignored. ssm_done in the same cycle as watchdog expiry: done wins, no error.
- Operand flat registers hold their values from the end of LOAD through DRAIN. A new frame overwrites them word by word.
- Reset mid-operation aborts immediately: no ssm_start, partial frame discarded.
- err_timeout persists until rst_n or the first word of the next frame.

Decomposition:
- Shared package: FP16 word width, operand field offsets (OFF_DT=0, OFF_DA=H, OFF_B=2H, OFF_C=2H+N, OFF_D=2H+2N, OFF_X=3H+2N, OFF_H=3H+2N+H*P), frame length L, state encoding.
- One natural sub-module, ssm_word_serializer: the DRAIN-side buffer, index counter and valid/ready/last logic.
- Field decode (word counter to target flat slice) stays in the top.

Test Plan:
- Defaults, 100 words with in_data=word index, in_valid always high → ssm_start one pulse exactly 1 cycle after the 100th handshake; dt_flat[15:0]=0x0000, Bmat_flat[15:0]=0x0008, h_prev_flat last word=0x0063.
- Model ssm_done 20 cycles after start with ssm_y_flat elements y[j]=0x3C00+j, out_ready=1 → 16 consecutive words 0x3C00..0x3C0F, out_last only on 0x3C0F, then busy=0.
- Random in_valid gaps (50%) plus out_ready toggling → identical captured operands and output sequence; out_data held constant during every stall.
- ssm_done never asserted, WAIT_MAX=64 → err_timeout=1 at cycle 64 of WAIT, state IDLE, no out_valid. Next frame's first word clears err_timeout.
- rst_n dropped at word 50 of the load, then a full new frame → no ssm_start from the aborted frame; the new frame completes normally.
- Spurious ssm_done during LOAD, then done coincident with watchdog expiry → the spurious pulse is ignored; coincident case drains output with err_timeout=0.
